// File: rtl/nor_bus_sequencer_if.sv
// Wishbone pipelined request/response bundle between the NOR request path and nor_bus_sequencer.
// wb_err_o exists only when NOR_BUSY_TIMEOUT_EN is defined.
interface nor_bus_sequencer_if;
   logic [31:0] wb_adr_i;
   logic [15:0] wb_dat_i;
   logic        wb_we_i;
   logic        wb_stb_i;
   logic        wb_cyc_i;
   logic        wb_ack_o;
   logic [15:0] wb_dat_o;
   logic        wb_stall_o;
`ifdef NOR_BUSY_TIMEOUT_EN
   logic        wb_err_o;
`endif

   modport slave (
      input  wb_adr_i, wb_dat_i, wb_we_i, wb_stb_i, wb_cyc_i,
      output wb_ack_o, wb_dat_o, wb_stall_o
`ifdef NOR_BUSY_TIMEOUT_EN
      , wb_err_o
`endif
   );

   modport master (
      output wb_adr_i, wb_dat_i, wb_we_i, wb_stb_i, wb_cyc_i,
      input  wb_ack_o, wb_dat_o, wb_stall_o
`ifdef NOR_BUSY_TIMEOUT_EN
      , wb_err_o
`endif
   );
endinterface

// File: rtl/nor_bus_sequencer.sv
// Pipelined Wishbone slave turning single-word requests into timed NOR cycles (setup, access, hold).
// Optional NOR_BUSY_TIMEOUT_EN: a write blocked by RY low for BUSY_TIMEOUT cycles is dropped with wb_err_o.
module nor_bus_sequencer #(
   parameter int T_SETUP = 2,
   parameter int T_RD    = 4,
   parameter int T_WR    = 3,
   parameter int T_HOLD  = 1
`ifdef NOR_BUSY_TIMEOUT_EN
   ,
   parameter int BUSY_TIMEOUT = 1024
`endif
) (
   input  logic                clk_i,
   input  logic                reset_ni,
   nor_bus_sequencer_if.slave  wb,
   input  logic                nor_ry_i,
   input  logic [15:0]         nor_data_i,
   output logic [15:0]         nor_data_o,
   output logic [25:0]         nor_addr_o,
   output logic                nor_ce_o,
   output logic                nor_we_o,
   output logic                nor_oe_o,
   output logic                nor_data_oe
);

   localparam int M_A  = (T_SETUP > T_RD) ? T_SETUP : T_RD;
   localparam int M_B  = (T_WR > T_HOLD) ? T_WR : T_HOLD;
   localparam int MAXP = (M_A > M_B) ? M_A : M_B;
   localparam int CW   = $clog2(MAXP + 1);

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS, HOLD} state_e;

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [25:0]   adr_q, adr_d;
   logic [15:0]   wdat_q, wdat_d;
   logic [15:0]   rdat_q, rdat_d;
   logic          we_q, we_d;
   logic          ack_q, ack_d;
   logic          ce_q, ce_d, oe_q, oe_d, wen_q, wen_d, doe_q, doe_d;
   logic          stall, accept, timeout_hit;
   logic          unused_adr_hi;

   assign unused_adr_hi = ^wb.wb_adr_i[31:26];

`ifdef NOR_BUSY_TIMEOUT_EN
   localparam int BW = $clog2(BUSY_TIMEOUT + 1);
   logic [BW-1:0] busy_cnt_q, busy_cnt_d;
   logic          err_q, err_d, wr_blocked;

   always_comb begin
      wr_blocked  = wb.wb_cyc_i & wb.wb_stb_i & wb.wb_we_i & ~nor_ry_i;
      timeout_hit = wr_blocked & (state_q == IDLE) & (busy_cnt_q == BW'(BUSY_TIMEOUT - 1));
      err_d       = timeout_hit;
      busy_cnt_d  = '0;
      if (wr_blocked && !timeout_hit) begin
         busy_cnt_d = (busy_cnt_q == BW'(BUSY_TIMEOUT - 1)) ? busy_cnt_q : busy_cnt_q + BW'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (!reset_ni) begin
         busy_cnt_q <= '0;
         err_q      <= 1'b0;
      end else begin
         busy_cnt_q <= busy_cnt_d;
         err_q      <= err_d;
      end
   end

   assign wb.wb_err_o = err_q;
`else
   assign timeout_hit = 1'b0;
`endif

   // Reads ignore RY so a busy part can still be polled for status.
   assign stall      = (state_q != IDLE) | (wb.wb_we_i & ~nor_ry_i & ~timeout_hit);
   assign accept     = wb.wb_cyc_i & wb.wb_stb_i & ~stall & ~timeout_hit;
   assign wb.wb_stall_o = stall;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      adr_d   = adr_q;
      wdat_d  = wdat_q;
      rdat_d  = rdat_q;
      we_d    = we_q;
      ack_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               adr_d   = wb.wb_adr_i[25:0];
               wdat_d  = wb.wb_dat_i;
               we_d    = wb.wb_we_i;
               state_d = SETUP;
               cnt_d   = CW'(T_SETUP - 1);
            end
         end
         SETUP: begin
            if (cnt_q == '0) begin
               state_d = ACCESS;
               cnt_d   = we_q ? CW'(T_WR - 1) : CW'(T_RD - 1);
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         ACCESS: begin
            if (cnt_q == '0) begin
               state_d = HOLD;
               cnt_d   = CW'(T_HOLD - 1);
               ack_d   = 1'b1;
               if (!we_q) rdat_d = nor_data_i;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         HOLD: begin
            if (cnt_q == '0) state_d = IDLE;
            else             cnt_d = cnt_q - CW'(1);
         end
         default: state_d = IDLE;
      endcase

      // Pad strobes are registered from the next state so they never glitch.
      ce_d  = !(state_d == SETUP || state_d == ACCESS);
      oe_d  = !(state_d == ACCESS && !we_d);
      wen_d = !(state_d == ACCESS && we_d);
      doe_d = we_d && (state_d != IDLE);
   end

   always_ff @(posedge clk_i) begin
      if (!reset_ni) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         adr_q   <= '0;
         wdat_q  <= '0;
         rdat_q  <= '0;
         we_q    <= 1'b0;
         ack_q   <= 1'b0;
         ce_q    <= 1'b1;
         oe_q    <= 1'b1;
         wen_q   <= 1'b1;
         doe_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         adr_q   <= adr_d;
         wdat_q  <= wdat_d;
         rdat_q  <= rdat_d;
         we_q    <= we_d;
         ack_q   <= ack_d;
         ce_q    <= ce_d;
         oe_q    <= oe_d;
         wen_q   <= wen_d;
         doe_q   <= doe_d;
      end
   end

   // A master that abandons the cycle still gets a complete NOR cycle, just no ack.
   assign wb.wb_ack_o = ack_q & wb.wb_cyc_i;
   assign wb.wb_dat_o = rdat_q;
   assign nor_addr_o  = adr_q;
   assign nor_data_o  = wdat_q;
   assign nor_ce_o    = ce_q;
   assign nor_oe_o    = oe_q;
   assign nor_we_o    = wen_q;
   assign nor_data_oe = doe_q;

endmodule

// File: tb/tb_nor_bus_sequencer.sv
// Bench for nor_bus_sequencer: directed scenarios plus random traffic against a transaction-timing model.
`timescale 1ns/1ps
module tb_nor_bus_sequencer;
   localparam int T_SETUP = 2;
   localparam int T_RD    = 4;
   localparam int T_WR    = 3;
   localparam int T_HOLD  = 1;

   logic        clk_i = 1'b0;
   logic        reset_ni = 1'b0;
   logic        nor_ry_i = 1'b1;
   logic [15:0] nor_data_i = '0;
   logic [15:0] nor_data_o;
   logic [25:0] nor_addr_o;
   logic        nor_ce_o, nor_we_o, nor_oe_o, nor_data_oe;

   nor_bus_sequencer_if wb();

   nor_bus_sequencer #(.T_SETUP(T_SETUP), .T_RD(T_RD), .T_WR(T_WR), .T_HOLD(T_HOLD)) dut (
      .clk_i(clk_i), .reset_ni(reset_ni), .wb(wb), .nor_ry_i(nor_ry_i), .nor_data_i(nor_data_i),
      .nor_data_o(nor_data_o), .nor_addr_o(nor_addr_o), .nor_ce_o(nor_ce_o), .nor_we_o(nor_we_o),
      .nor_oe_o(nor_oe_o), .nor_data_oe(nor_data_oe)
   );

   always #5 clk_i = ~clk_i;

   int n_chk = 0, n_pass = 0, cyc_n = 0;

   // next-cycle stimulus, applied just after the rising edge
   logic        rst_nxt = 1'b0, ry_nxt = 1'b1, cyc_idle = 1'b1, idle_we = 1'b0;
   logic [15:0] ndat_nxt = '0;
   logic        req_pend = 1'b0, req_we = 1'b0;
   logic [31:0] req_adr = '0;
   logic [15:0] req_dat = '0;

   // transaction-level model
   bit          acc_valid = 0, acc_we = 0, accepted = 0;
   int          acc_cycle = 0, ack_count = 0, last_ack_k = -1;
   logic [25:0] m_adr = '0;
   logic [15:0] m_dat = '0, m_rdat = '0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc_n);
   endtask

   task automatic model_cycle();
      int   k, a;
      bit   in_strobe, in_acc, busy;
      logic exp_stall;
      k = acc_valid ? (cyc_n - acc_cycle) : 0;
      a = T_SETUP + (acc_we ? T_WR : T_RD);
      in_strobe = acc_valid && k >= 1 && k <= a;
      in_acc    = acc_valid && k >= T_SETUP + 1 && k <= a;
      busy      = acc_valid && k >= 1 && k <= a + T_HOLD;
      exp_stall = busy | (wb.wb_we_i & ~nor_ry_i);
      check_eq("stall", wb.wb_stall_o, exp_stall);
      check_eq("ack", wb.wb_ack_o, acc_valid && k == a + 1 && wb.wb_cyc_i);
      check_eq("ce", nor_ce_o, !in_strobe);
      check_eq("oe", nor_oe_o, !(in_acc && !acc_we));
      check_eq("we", nor_we_o, !(in_acc && acc_we));
      check_eq("data_oe", nor_data_oe, busy && acc_we);
      check_eq("addr", nor_addr_o, m_adr);
      check_eq("data_o", nor_data_o, m_dat);
      check_eq("rdat", wb.wb_dat_o, m_rdat);
      if (wb.wb_ack_o === 1'b1) begin
         ack_count++;
         last_ack_k = k;
      end
      accepted = 0;
      if (!reset_ni) begin
         acc_valid = 0; m_adr = '0; m_dat = '0; m_rdat = '0;
      end else begin
         if (acc_valid && !acc_we && k == a) m_rdat = nor_data_i;
         if (wb.wb_cyc_i && wb.wb_stb_i && !exp_stall) begin
            accepted = 1; acc_valid = 1; acc_cycle = cyc_n; acc_we = wb.wb_we_i;
            m_adr = wb.wb_adr_i[25:0]; m_dat = wb.wb_dat_i;
         end
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
      cyc_n++;
      reset_ni   = rst_nxt;
      nor_ry_i   = ry_nxt;
      nor_data_i = ndat_nxt;
      wb.wb_stb_i = req_pend;
      wb.wb_cyc_i = req_pend | cyc_idle;
      wb.wb_we_i  = req_pend ? req_we : idle_we;
      wb.wb_adr_i = req_adr;
      wb.wb_dat_i = req_dat;
      @(negedge clk_i);
      model_cycle();
      if (accepted) req_pend = 1'b0;
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic request(input logic we, input logic [31:0] adr, input logic [15:0] dat);
      req_pend = 1'b1; req_we = we; req_adr = adr; req_dat = dat;
   endtask

   task automatic wait_accept(input string tag);
      int n;
      n = 0;
      do begin
         step();
         n++;
      end while (!accepted && n < 200);
      check_eq({tag, "_accepted"}, accepted, 1'b1);
   endtask

   int a1, a2, t0, ack_base;

   initial begin
      wb.wb_adr_i = '0; wb.wb_dat_i = '0; wb.wb_we_i = 1'b0; wb.wb_stb_i = 1'b0; wb.wb_cyc_i = 1'b0;
      steps(2);
      rst_nxt = 1'b1;
      steps(2);

      // single read
      ndat_nxt = 16'hBEEF;
      t0 = cyc_n + 1;
      request(1'b0, 32'h0001_234, 16'h0);
      wait_accept("t1");
      check_eq("t1_acc_cycle", acc_cycle, t0);
      steps(8);
      check_eq("t1_ack_k", last_ack_k, 7);
      check_eq("t1_rdat", wb.wb_dat_o, 16'hBEEF);
      check_eq("t1_addr", nor_addr_o, 26'h0001234);

      // single write at top of address space; upper address bits ignored
      ndat_nxt = 16'h1111;
      request(1'b1, 32'hFFFF_FFFF, 16'hA55A);
      wait_accept("t2");
      steps(7);
      check_eq("t2_ack_k", last_ack_k, 6);
      check_eq("t2_rdat_kept", wb.wb_dat_o, 16'hBEEF);
      check_eq("t2_addr", nor_addr_o, 26'h3FFFFFF);
      check_eq("t2_wdat", nor_data_o, 16'hA55A);

      // write blocked by RY, then read while busy
      ry_nxt = 1'b0;
      request(1'b1, 32'h0000_0042, 16'h5AA5);
      steps(20);
      check_eq("t3_still_pending", req_pend, 1'b1);
      ry_nxt = 1'b1;
      t0 = cyc_n + 1;
      wait_accept("t3w");
      check_eq("t3_acc_on_ry", acc_cycle, t0);
      steps(7);
      check_eq("t3_ack_k", last_ack_k, 6);
      ry_nxt = 1'b0;
      t0 = cyc_n + 1;
      request(1'b0, 32'h0000_0100, 16'h0);
      wait_accept("t3r");
      check_eq("t3_read_busy_acc", acc_cycle, t0);
      steps(8);
      ry_nxt = 1'b1;

      // back-to-back read then write with stb held
      ack_base = ack_count;
      request(1'b0, 32'h0000_0200, 16'h0);
      wait_accept("t4a");
      a1 = acc_cycle;
      request(1'b1, 32'h0000_0201, 16'h1234);
      wait_accept("t4b");
      a2 = acc_cycle;
      check_eq("t4_second_acc", a2 - a1, 8);
      steps(8);
      check_eq("t4_second_ack_k", last_ack_k, 6);
      check_eq("t4_ack_pulses", ack_count - ack_base, 2);

      // reset during the last access cycle of a read
      request(1'b0, 32'h0000_0300, 16'h0);
      wait_accept("t5");
      steps(5);
      rst_nxt = 1'b0;
      step();
      rst_nxt = 1'b1;
      ack_base = ack_count;
      step();
      check_eq("t5_ce_idle", nor_ce_o, 1'b1);
      check_eq("t5_oe_idle", nor_oe_o, 1'b1);
      check_eq("t5_doe_off", nor_data_oe, 1'b0);
      steps(3);
      check_eq("t5_no_ack", ack_count - ack_base, 0);
      request(1'b0, 32'h0000_0301, 16'h0);
      wait_accept("t5b");
      steps(8);
      check_eq("t5_ack_k", last_ack_k, 7);

      // random traffic
      for (int i = 0; i < 3000; i++) begin
         if (!req_pend && ($urandom % 2 == 0))
            request(1'($urandom % 2), $urandom, 16'($urandom));
         if ($urandom % 8 == 0) ry_nxt = ~ry_nxt;
         cyc_idle = ($urandom % 4 != 0);
         idle_we  = 1'($urandom % 2);
         ndat_nxt = 16'($urandom);
         rst_nxt  = ($urandom % 400 != 0);
         step();
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
